mem_io_bridge: RTL and testbench



---
 rtl/mem_io_bridge_if.sv | 48 ++++
 rtl/mem_io_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_io_bridge.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_bridge_if.sv
// Bundle of the MEM-stage request/response handshake and the two data-side
// target buses (RAM and IO register block) seen by mem_io_bridge.
interface mem_io_bridge_if #(
    parameter int ADDR_W = 32
);
    // Request side (from the MEM pipeline stage)
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    // Response side
    logic              ack;
    logic              err;
    logic [31:0]       rdata;

    // RAM target
    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // IO target
    logic              io_ce;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;

    // The bridge itself
    modport slave (
        input  req, wr, size, sext, addr, wdata, ram_rdata, io_rdata,
        output ack, err, rdata,
        output ram_ce, ram_we, ram_addr, ram_wdata,
        output io_ce, io_we, io_addr, io_wdata
    );

    // The environment: MEM stage plus the two targets
    modport master (
        output req, wr, size, sext, addr, wdata, ram_rdata, io_rdata,
        input  ack, err, rdata,
        input  ram_ce, ram_we, ram_addr, ram_wdata,
        input  io_ce, io_we, io_addr, io_wdata
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Load/store bridge from the MEM stage to a RAM region and an IO region.
// Both targets accept only 32-bit big-endian word accesses, so byte and
// halfword stores are performed as read-modify-write. All outputs are
// registered; ce/we are additionally forced low while rst is high so an
// interrupted read-modify-write can never write.
module mem_io_bridge #(
    parameter int ADDR_W      = 32,
    parameter int RAM_BASE    = 0,
    parameter int IO_BASE     = 1024,
    parameter int REGION_SIZE = 1024
) (
    input  logic            clk,
    input  logic            rst,
    mem_io_bridge_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Region bounds one bit wider than the address so BASE+SIZE cannot wrap.
    localparam logic [ADDR_W:0] RAM_LO = (ADDR_W+1)'(RAM_BASE);
    localparam logic [ADDR_W:0] RAM_HI = (ADDR_W+1)'(RAM_BASE + REGION_SIZE);
    localparam logic [ADDR_W:0] IO_LO  = (ADDR_W+1)'(IO_BASE);
    localparam logic [ADDR_W:0] IO_HI  = (ADDR_W+1)'(IO_BASE + REGION_SIZE);

    state_t            state_q;

    // Latched request
    logic              wr_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       req_wdata_q;   // only sub-word stores need it after acceptance
    logic              sel_io_q;

    // Registered outputs
    logic              ack_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              ram_ce_q, ram_we_q, io_ce_q, io_we_q;
    logic [ADDR_W-1:0] ram_addr_q, io_addr_q;
    logic [31:0]       ram_wdata_q, io_wdata_q;

    // Combinational helpers
    logic [ADDR_W:0]   addr_x_d;
    logic              in_ram_d;
    logic              in_io_d;
    logic              err_d;
    logic [ADDR_W-1:0] req_word_addr_d;
    logic [ADDR_W-1:0] cur_word_addr_d;
    logic [31:0]       tgt_rdata_d;
    logic [7:0]        byte_lane_d;
    logic [15:0]       half_lane_d;
    logic [31:0]       load_d;
    logic [31:0]       merge_d;

    // Decode of the incoming request and lane extract/insert on the target word
    always_comb begin
        addr_x_d        = {1'b0, bus.addr};
        in_ram_d        = (addr_x_d >= RAM_LO) && (addr_x_d < RAM_HI);
        in_io_d         = (addr_x_d >= IO_LO)  && (addr_x_d < IO_HI);
        err_d           = !(in_ram_d || in_io_d)
                        || (bus.size == SZ_ILL)
                        || ((bus.size == SZ_HALF) && bus.addr[0])
                        || ((bus.size == SZ_WORD) && (bus.addr[1:0] != 2'b00));
        req_word_addr_d = {bus.addr[ADDR_W-1:2], 2'b00};
        cur_word_addr_d = {addr_q[ADDR_W-1:2], 2'b00};

        // Only the selected target's read data is meaningful.
        tgt_rdata_d = sel_io_q ? bus.io_rdata : bus.ram_rdata;

        // Big-endian lanes: offset 0 is the most significant byte.
        byte_lane_d = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_lane_d = tgt_rdata_d[31:24];
            2'd1:    byte_lane_d = tgt_rdata_d[23:16];
            2'd2:    byte_lane_d = tgt_rdata_d[15:8];
            default: byte_lane_d = tgt_rdata_d[7:0];
        endcase
        half_lane_d = addr_q[1] ? tgt_rdata_d[15:0] : tgt_rdata_d[31:16];

        load_d = tgt_rdata_d;
        case (size_q)
            SZ_BYTE: load_d = {{24{sext_q & byte_lane_d[7]}}, byte_lane_d};
            SZ_HALF: load_d = {{16{sext_q & half_lane_d[15]}}, half_lane_d};
            default: load_d = tgt_rdata_d;
        endcase

        merge_d = tgt_rdata_d;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merge_d[31:24] = req_wdata_q[7:0];
                2'd1:    merge_d[23:16] = req_wdata_q[7:0];
                2'd2:    merge_d[15:8]  = req_wdata_q[7:0];
                default: merge_d[7:0]   = req_wdata_q[7:0];
            endcase
        end else if (size_q == SZ_HALF) begin
            if (addr_q[1]) merge_d[15:0]  = req_wdata_q;
            else           merge_d[31:16] = req_wdata_q;
        end
    end

    // Control FSM; every output is registered and computed for the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            req_wdata_q <= '0;
            sel_io_q    <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            io_ce_q     <= 1'b0;
            io_we_q     <= 1'b0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
        end else begin
            // Idle values for the target buses and response; states override.
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            io_ce_q     <= 1'b0;
            io_we_q     <= 1'b0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;

            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        wr_q        <= bus.wr;
                        size_q      <= bus.size;
                        sext_q      <= bus.sext;
                        addr_q      <= bus.addr;
                        req_wdata_q <= bus.wdata[15:0];
                        sel_io_q    <= in_io_d;
                        if (err_d) begin
                            state_q <= ACK;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            ram_ce_q   <= !in_io_d;
                            io_ce_q    <= in_io_d;
                            ram_addr_q <= in_io_d ? '0 : req_word_addr_d;
                            io_addr_q  <= in_io_d ? req_word_addr_d : '0;
                            if (bus.wr && (bus.size == SZ_WORD)) begin
                                // Full word store skips the read.
                                state_q     <= WR;
                                ram_we_q    <= !in_io_d;
                                io_we_q     <= in_io_d;
                                ram_wdata_q <= in_io_d ? 32'h0 : bus.wdata;
                                io_wdata_q  <= in_io_d ? bus.wdata : 32'h0;
                            end else begin
                                state_q <= RD;
                            end
                        end
                    end
                end

                RD: begin
                    if (wr_q) begin
                        // Write back the read word with the addressed lane replaced.
                        state_q     <= WR;
                        ram_ce_q    <= !sel_io_q;
                        io_ce_q     <= sel_io_q;
                        ram_we_q    <= !sel_io_q;
                        io_we_q     <= sel_io_q;
                        ram_addr_q  <= sel_io_q ? '0 : cur_word_addr_d;
                        io_addr_q   <= sel_io_q ? cur_word_addr_d : '0;
                        ram_wdata_q <= sel_io_q ? 32'h0 : merge_d;
                        io_wdata_q  <= sel_io_q ? merge_d : 32'h0;
                    end else begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                        rdata_q <= load_d;
                    end
                end

                WR: begin
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_ce    = ram_ce_q & ~rst;
    assign bus.ram_we    = ram_we_q & ~rst;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.io_ce     = io_ce_q & ~rst;
    assign bus.io_we     = io_we_q & ~rst;
    assign bus.io_addr   = io_addr_q;
    assign bus.io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge. The driver computes each expected
// response from a byte-addressed big-endian memory model and queues it; a
// separate monitor measures every transaction on the bus and compares.
module tb_mem_io_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_io_bridge_if #(.ADDR_W(32)) bus ();

    mem_io_bridge #(
        .ADDR_W(32), .RAM_BASE(0), .IO_BASE(1024), .REGION_SIZE(1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          ram_ce;
        int          io_ce;
        int          we;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          txn   = 0;
    int          io_we_total = 0;
    byte unsigned ref_mem[2048];
    logic [31:0] ram_w[256];
    logic [31:0] io_w[256];

    // Target models: combinational read, word write on posedge.
    assign bus.ram_rdata = bus.ram_ce ? ram_w[bus.ram_addr[9:2]] : 32'h0;
    assign bus.io_rdata  = bus.io_ce  ? io_w[bus.io_addr[9:2]]   : 32'h0;
    always @(posedge clk) begin
        if (bus.ram_ce && bus.ram_we) ram_w[bus.ram_addr[9:2]] <= bus.ram_wdata;
        if (bus.io_ce && bus.io_we)   io_w[bus.io_addr[9:2]]   <= bus.io_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference behaviour from the access rules, on a flat byte array.
    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sx,
                                   input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic in_ram, in_io;
        int   nb;
        logic [31:0] v;
        in_ram = (a < 32'd1024);
        in_io  = (a >= 32'd1024) && (a < 32'd2048);
        e.err = !(in_ram || in_io) || (sz == 2'd3) || (sz == 2'd1 && a[0])
              || (sz == 2'd2 && a[1:0] != 2'd0);
        e.rdata = 32'h0; e.lat = 1; e.ram_ce = 0; e.io_ce = 0; e.we = 0;
        if (!e.err) begin
            nb = 1 << sz;
            if (!w) begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[int'(a) + i]);
                if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                e.rdata = v; e.lat = 2;
                if (in_io) e.io_ce = 1; else e.ram_ce = 1;
            end else begin
                for (int i = 0; i < nb; i++)
                    ref_mem[int'(a) + i] = 8'(d >> (8*(nb-1-i)));
                e.lat = (nb == 4) ? 2 : 3;
                e.we  = 1;
                if (in_io) e.io_ce = (nb == 4) ? 1 : 2;
                else       e.ram_ce = (nb == 4) ? 1 : 2;
            end
        end
        return e;
    endfunction

    // Issue one request; called just after a posedge, returns just after a posedge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        sb.push_back(model(w, sz, sx, a, d));
        bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.sext = sx;
        bus.addr = a; bus.wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            // Fields change mid-operation; the bridge must ignore them.
            if (n == 2 && !bus.ack) begin
                bus.addr  = $urandom;
                bus.wdata = $urandom;
                bus.size  = 2'($urandom_range(0, 3));
                bus.wr    = 1'($urandom_range(0, 1));
            end
        end while (!bus.ack && n < 20);
        if (!bus.ack) begin
            tests++; fails++;
            $display("FAIL ack_timeout: no ack after %0d cycles for addr %h", n, a);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1);
        end
        bus.req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: measures latency and target activity per transaction.
    int  mon_cnt, mon_rce, mon_ice, mon_we;
    bit  mon_busy = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else begin
            if (bus.ram_ce && bus.io_ce) check("ce_onehot", 32'(bus.io_ce), 32'd0);
            if (bus.io_we) io_we_total++;
            if (mon_busy) begin
                mon_cnt++;
                mon_rce += int'(bus.ram_ce);
                mon_ice += int'(bus.io_ce);
                mon_we  += int'(bus.ram_we | bus.io_we);
                if (bus.ack) begin
                    exp_t e;
                    mon_busy = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        txn++;
                        $display("[TB] txn %0d err=%0d rdata=%h lat=%0d ram_ce=%0d io_ce=%0d we=%0d",
                                 txn, bus.err, bus.rdata, mon_cnt, mon_rce, mon_ice, mon_we);
                        check("err",     32'(bus.err), 32'(e.err));
                        check("rdata",   bus.rdata,    e.rdata);
                        check("latency", 32'(mon_cnt), 32'(e.lat));
                        check("ram_ce",  32'(mon_rce), 32'(e.ram_ce));
                        check("io_ce",   32'(mon_ice), 32'(e.io_ce));
                        check("we",      32'(mon_we),  32'(e.we));
                    end
                end
            end else begin
                if (bus.ack || bus.ram_ce || bus.io_ce)
                    check("idle_activity", {29'd0, bus.ack, bus.ram_ce, bus.io_ce}, 32'd0);
                if (bus.req) begin
                    mon_busy = 1'b1;
                    mon_cnt = 0; mon_rce = 0; mon_ice = 0; mon_we = 0;
                end
            end
        end
    end

    initial begin
        int          we_before;
        logic [31:0] a;
        logic [1:0]  sz;

        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            ram_w[i] = {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]};
            io_w[i]  = {ref_mem[1024+4*i], ref_mem[1025+4*i], ref_mem[1026+4*i], ref_mem[1027+4*i]};
        end
        bus.req = 0; bus.wr = 0; bus.size = 0; bus.sext = 0; bus.addr = 0; bus.wdata = 0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   32'(bus.ack), 32'd0);
        check("rst_err",   32'(bus.err), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_ce",    {30'd0, bus.ram_ce, bus.io_ce}, 32'd0);
        check("rst_addr",  bus.ram_addr | bus.io_addr, 32'd0);
        check("rst_wdata", bus.ram_wdata | bus.io_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed accesses
        issue(1, 2'd2, 0, 32'h400, 32'h1122_3344);
        issue(0, 2'd2, 0, 32'h400, 32'h0);
        issue(1, 2'd0, 0, 32'h402, 32'h0000_00AA);
        issue(0, 2'd2, 0, 32'h400, 32'h0);
        issue(0, 2'd0, 1, 32'h402, 32'h0);
        issue(0, 2'd0, 0, 32'h402, 32'h0);
        issue(0, 2'd1, 1, 32'h400, 32'h0);
        issue(0, 2'd1, 0, 32'h401, 32'h0);
        issue(1, 2'd2, 0, 32'h402, 32'h5555_5555);
        issue(0, 2'd2, 0, 32'h800, 32'h0);
        issue(0, 2'd3, 0, 32'h400, 32'h0);
        issue(1, 2'd2, 0, 32'h3FC, 32'hDEAD_BEEF);
        issue(0, 2'd2, 0, 32'h3FC, 32'h0);
        issue(1, 2'd2, 0, 32'h7FC, 32'hCAFE_F00D);
        issue(0, 2'd2, 0, 32'h7FC, 32'h0);
        issue(1, 2'd1, 0, 32'h7FE, 32'h0000_8001);
        issue(0, 2'd1, 1, 32'h7FE, 32'h0);

        // Byte store to 0x404 interrupted by reset during its read cycle
        we_before = io_we_total;
        bus.req = 1; bus.wr = 1; bus.size = 2'd0; bus.sext = 0;
        bus.addr = 32'h404; bus.wdata = 32'h0000_0077;
        @(posedge clk); #1;
        rst = 1'b1; bus.req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_abort_ack", 32'(bus.ack), 32'd0);
            @(posedge clk); #1;
        end
        check("rst_abort_io_we", 32'(io_we_total), 32'(we_before));
        issue(0, 2'd2, 0, 32'h404, 32'h0);

        // Randomized traffic, biased toward region edges and illegal cases
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0: a = ($urandom_range(0, 1) == 0) ? (32'h800 + $urandom_range(0, 2047)) : 32'hFFFF_FFFC;
                1: begin
                    case ($urandom_range(0, 4))
                        0: a = 32'h3FC; 1: a = 32'h400; 2: a = 32'h7FC;
                        3: a = 32'h7FE; default: a = 32'h7FF;
                    endcase
                end
                default: a = 32'($urandom_range(0, 2047));
            endcase
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3 && sz != 2'd0)
                a = (sz == 2'd2) ? {a[31:2], 2'b00} : {a[31:1], 1'b0};
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
